// File: rtl/pid_pkg.sv
// Shared types and helpers for the time-multiplexed multi-channel PID controller.
package pid_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERR,
        MP,
        MI,
        MD,
        ACC,
        DONE
    } state_t;

    // Default number of fractional bits of the Q-format gains (1.0 = 2**Q_FRAC).
    localparam int Q_FRAC = 15;

    // Signed clamp for any operand width up to 64 bits.
    // The caller sign-extends the operand and truncates the result.
    function automatic longint sat(input longint x, input longint lo, input longint hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/pid_mul.sv
// Shared registered signed multiplier: (a * b) >>> FRAC, with one cycle of latency.
module pid_mul
    import pid_pkg::*;
#(
    parameter int W    = 19,
    parameter int FRAC = Q_FRAC
) (
    input  logic                  up_clk,
    input  logic                  rst,
    input  logic signed [W-1:0]   i_a,
    input  logic signed [W+1:0]   i_b,
    output logic signed [2*W+1:0] o_p
);

    logic signed [2*W+1:0] w_full;
    logic signed [2*W+1:0] r_p;

    // Both operands are widened first so that the product is formed at full width.
    assign w_full = (2*W+2)'(i_a) * (2*W+2)'(i_b);
    assign o_p    = r_p;

    always_ff @(posedge up_clk or posedge rst) begin
        if (rst) begin
            r_p <= '0;
        end else begin
            r_p <= w_full >>> FRAC;
        end
    end

endmodule

// File: rtl/pid_ctrl_mc.sv
// N_CH-channel PID controller; one shared multiplier, five cycles per channel.
module pid_ctrl_mc
    import pid_pkg::*;
#(
    parameter int W       = 19,
    parameter int FRAC    = Q_FRAC,
    parameter int N_CH    = 4,
    parameter int INT_LIM = 2**(W-1)-1,
    parameter int OUT_MAX = 2**(W-1)-1,
    parameter int OUT_MIN = -(2**(W-1))
) (
    input  logic              up_clk,
    input  logic              rst,
    input  logic              sample_start,
    input  logic [N_CH*W-1:0] N_ref,
    input  logic [N_CH*W-1:0] N_fb,
    input  logic [N_CH*W-1:0] K_p,
    input  logic [N_CH*W-1:0] K_i,
    input  logic [N_CH*W-1:0] K_d,
    input  logic [N_CH-1:0]   int_clr,
    output logic [N_CH*W-1:0] N_con,
    output logic              busy,
    output logic              done
);

    localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int ACC_W = 2*W+3;
    localparam logic signed [W-1:0] L_OUT_MAX = W'(OUT_MAX);
    localparam logic signed [W-1:0] L_OUT_MIN = W'(OUT_MIN);

    state_t                r_state, w_next;
    logic [CW-1:0]         r_ch;
    logic signed [W:0]     r_e;
    logic signed [W+1:0]   r_de;
    logic signed [W-1:0]   r_kp, r_ki, r_kd;
    logic signed [2*W+1:0] r_p, r_iinc;

    logic signed [W-1:0]   r_int   [N_CH];
    logic signed [W:0]     r_eprev [N_CH];
    logic signed [W-1:0]   r_ncon  [N_CH];

    logic signed [W-1:0]   w_ref, w_fb;
    logic signed [W:0]     w_e;
    logic signed [W+1:0]   w_de;
    logic signed [W-1:0]   w_mul_a;
    logic signed [W+1:0]   w_mul_b;
    logic signed [2*W+1:0] w_mul;
    logic signed [ACC_W-1:0] w_isum, w_u;
    logic signed [W-1:0]   w_inew, w_int_upd, w_ncon_new;
    logic                  w_hold;

    assign w_ref = N_ref[r_ch*W +: W];
    assign w_fb  = N_fb[r_ch*W +: W];
    assign w_e   = (W+1)'(w_ref) - (W+1)'(w_fb);
    assign w_de  = (W+2)'(w_e) - (W+2)'(r_eprev[r_ch]);

    // Integrator candidate, anti-windup hold, and saturated output; w_mul carries d in ACC.
    assign w_isum     = ACC_W'(r_int[r_ch]) + ACC_W'(r_iinc);
    assign w_inew     = W'(sat(64'(w_isum), -longint'(INT_LIM), longint'(INT_LIM)));
    assign w_hold     = ((r_ncon[r_ch] == L_OUT_MAX) && !r_iinc[2*W+1] && (r_iinc != '0)) ||
                        ((r_ncon[r_ch] == L_OUT_MIN) &&  r_iinc[2*W+1]);
    assign w_int_upd  = w_hold ? r_int[r_ch] : w_inew;
    assign w_u        = ACC_W'(r_p) + ACC_W'(w_int_upd) + ACC_W'(w_mul);
    assign w_ncon_new = W'(sat(64'(w_u), longint'(OUT_MIN), longint'(OUT_MAX)));

    pid_mul #(
        .W    (W),
        .FRAC (FRAC)
    ) u_mul (
        .up_clk (up_clk),
        .rst    (rst),
        .i_a    (w_mul_a),
        .i_b    (w_mul_b),
        .o_p    (w_mul)
    );

    // NOTE: every signal is given a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        w_next  = r_state;
        busy    = (r_state != IDLE);
        done    = (r_state == DONE);
        w_mul_a = r_kp;
        w_mul_b = (W+2)'(r_e);
        case (r_state)
            IDLE:    if (sample_start) w_next = ERR;
            ERR:     w_next = MP;
            MP:      w_next = MI;
            MI:      begin w_next = MD; w_mul_a = r_ki; end
            MD:      begin w_next = ACC; w_mul_a = r_kd; w_mul_b = r_de; end
            ACC:     w_next = (r_ch == CW'(N_CH-1)) ? DONE : ERR;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge up_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_ch    <= '0;
            r_e     <= '0;
            r_de    <= '0;
            r_kp    <= '0;
            r_ki    <= '0;
            r_kd    <= '0;
            r_p     <= '0;
            r_iinc  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (sample_start) r_ch <= '0;
                ERR: begin
                    r_e  <= w_e;
                    r_de <= w_de;
                    r_kp <= K_p[r_ch*W +: W];
                    r_ki <= K_i[r_ch*W +: W];
                    r_kd <= K_d[r_ch*W +: W];
                end
                MI:      r_p    <= w_mul;
                MD:      r_iinc <= w_mul;
                ACC:     r_ch   <= r_ch + CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: per-channel arrays are flops and are reset explicitly; RAM-style storage would not be.
    always_ff @(posedge up_clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_CH; k++) begin
                r_int[k]   <= '0;
                r_eprev[k] <= '0;
                r_ncon[k]  <= '0;
            end
        end else begin
            if (r_state == ACC) begin
                r_int[r_ch]   <= w_int_upd;
                r_eprev[r_ch] <= r_e;
                r_ncon[r_ch]  <= w_ncon_new;
            end
            // A clear is written last so it overrides the ACC update of the same channel.
            for (int k = 0; k < N_CH; k++) begin
                if (int_clr[k]) begin
                    r_int[k]   <= '0;
                    r_eprev[k] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_out
        assign N_con[g*W +: W] = r_ncon[g];
    end

endmodule

// File: tb/tb_pid_ctrl_mc.sv
// Scoreboard bench for pid_ctrl_mc: directed updates with hand-computed outputs.
module tb_pid_ctrl_mc;

    localparam int W        = 19;
    localparam int FRAC     = 15;
    localparam int N_CH     = 4;
    localparam int OUT_MAX  = 1000;
    localparam int DONE_LAT = 5*N_CH+1;

    logic              up_clk = 1'b0;
    logic              rst;
    logic              sample_start;
    logic [N_CH*W-1:0] N_ref, N_fb, K_p, K_i, K_d, N_con;
    logic [N_CH-1:0]   int_clr;
    logic              busy, done;

    typedef struct {
        int                tag;
        int                done_cyc;
        logic [N_CH*W-1:0] ncon;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_done   = 0;
    int   n_pushed = 0;

    pid_ctrl_mc #(
        .W       (W),
        .FRAC    (FRAC),
        .N_CH    (N_CH),
        .OUT_MAX (OUT_MAX)
    ) dut (
        .up_clk       (up_clk),
        .rst          (rst),
        .sample_start (sample_start),
        .N_ref        (N_ref),
        .N_fb         (N_fb),
        .K_p          (K_p),
        .K_i          (K_i),
        .K_d          (K_d),
        .int_clr      (int_clr),
        .N_con        (N_con),
        .busy         (busy),
        .done         (done)
    );

    always #5 up_clk = ~up_clk;
    always @(posedge up_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic signed [63:0] ncon_of(input int c);
        return $signed(N_con[c*W +: W]);
    endfunction

    task automatic set_ch(input int c, input int r, input int f, input int kp, input int ki, input int kd);
        N_ref[c*W +: W] = W'(r);
        N_fb[c*W +: W]  = W'(f);
        K_p[c*W +: W]   = W'(kp);
        K_i[c*W +: W]   = W'(ki);
        K_d[c*W +: W]   = W'(kd);
    endtask

    // Caller is just after a negedge with the DUT idle; start is captured on the next posedge.
    task automatic start_update(input bit accept, input int tag, input int x0, input int x1, input int x2, input int x3);
        exp_t e;
        sample_start = 1'b1;
        @(posedge up_clk);
        #1;
        sample_start = 1'b0;
        if (accept) begin
            e.tag      = tag;
            e.done_cyc = cyc + DONE_LAT;
            e.ncon     = {W'(x3), W'(x2), W'(x1), W'(x0)};
            sb.push_back(e);
            n_pushed++;
        end
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            @(negedge up_clk);
        end
        check(name, busy, 0);
    endtask

    // Monitor: every done pulse pops one expectation and checks its timing and all outputs.
    always @(negedge up_clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                mon_e = sb.pop_front();
                check($sformatf("u%0d_done_cycle", mon_e.tag), cyc + 1, mon_e.done_cyc);
                for (int c = 0; c < N_CH; c++)
                    check($sformatf("u%0d_ncon%0d", mon_e.tag, c), ncon_of(c), $signed(mon_e.ncon[c*W +: W]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; sample_start = 1'b0; int_clr = '0;
        N_ref = '0; N_fb = '0; K_p = '0; K_i = '0; K_d = '0;
        repeat (2) @(negedge up_clk);
        for (int c = 0; c < N_CH; c++) check($sformatf("reset_ncon%0d", c), ncon_of(c), 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        rst = 1'b0;
        @(negedge up_clk);

        // U1: P-only ch0, integrator ch1, derivative ch2 (e=0), windup ch3.
        set_ch(0, 1000, 0, 32768, 0, 0);
        set_ch(1, 200, 0, 0, 16384, 0);
        set_ch(2, 0, 0, 0, 0, 32768);
        set_ch(3, 800, 0, 0, 32768, 0);
        start_update(1, 1, 1000, 100, 0, 800);
        repeat (5) @(negedge up_clk);
        check("u1_ch0_before_acc", ncon_of(0), 0);
        check("u1_busy", busy, 1);
        @(negedge up_clk);
        check("u1_ch0_at_cycle5", ncon_of(0), 1000);
        check("u1_ch1_before_acc", ncon_of(1), 0);
        repeat (5) @(negedge up_clk);
        check("u1_ch1_at_cycle10", ncon_of(1), 100);
        wait_idle("u1_idle");

        // U2: ch2 error steps to 500; ch3 clamps at OUT_MAX; a start while busy is ignored.
        set_ch(2, 500, 0, 0, 0, 32768);
        start_update(1, 2, 1000, 200, 500, 1000);
        repeat (8) @(negedge up_clk);
        sample_start = 1'b1;
        @(posedge up_clk);
        #1;
        sample_start = 1'b0;
        wait_idle("u2_idle");

        // U3: floor of -1.5 on ch0; ch3 integrator holds; a start during DONE is ignored.
        set_ch(0, -3, 0, 16384, 0, 0);
        start_update(1, 3, -2, 300, 0, 1000);
        for (int i = 0; i < 100; i++) begin
            @(negedge up_clk);
            if (done) break;
        end
        check("u3_done_seen", done, 1);
        sample_start = 1'b1;
        @(posedge up_clk);
        #1;
        sample_start = 1'b0;
        check("start_in_done_ignored", busy, 0);
        @(negedge up_clk);

        int_clr[1] = 1'b1;
        repeat (2) @(negedge up_clk);
        check("int_clr_keeps_ncon1", ncon_of(1), 300);
        int_clr = '0;

        // U4: negative P, ch1 integrator restarted, ch2 negative derivative, ch3 unwinds but stays clamped.
        set_ch(0, 0, 1500, 32768, 0, 0);
        set_ch(2, 200, 0, 0, 0, 32768);
        set_ch(3, -400, 0, 0, 32768, 0);
        start_update(1, 4, -1500, 100, -300, 1000);
        wait_idle("u4_idle");

        // U5: extreme errors exercise the W+1/W+2 widths and both output limits.
        set_ch(0, 262143, -262144, 32768, 0, 0);
        set_ch(2, -262144, 262143, 0, 0, 32768);
        start_update(1, 5, 1000, 200, -262144, 800);
        wait_idle("u5_idle");

        // U6: reset during the update aborts it and clears already-written channels.
        start_update(0, 6, 0, 0, 0, 0);
        repeat (7) @(negedge up_clk);
        rst = 1'b1;
        #1;
        for (int c = 0; c < N_CH; c++) check($sformatf("abort_ncon%0d", c), ncon_of(c), 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        repeat (2) @(negedge up_clk);
        rst = 1'b0;
        @(negedge up_clk);

        // U7: fresh state after reset; ch0 combines P, I and D.
        set_ch(0, 5, 0, 32768, 16384, 16384);
        set_ch(1, 200, 0, 0, 16384, 0);
        set_ch(2, 100, 0, 0, 0, 32768);
        set_ch(3, -400, 0, 0, 32768, 0);
        start_update(1, 7, 9, 100, 100, -400);
        wait_idle("u7_idle");
        repeat (3) @(negedge up_clk);

        check("scoreboard_empty", sb.size(), 0);
        check("done_count", n_done, n_pushed);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pid_ctrl_mc.md
# pid_ctrl_mc

Parametrised, multi-channel successor to the single-loop digital PID controller. It time-multiplexes one signed multiplier across `N_CH` independent PID loops, with the following per-channel features:
- gains in Q(W−FRAC).FRAC format;
- integrator clamping with anti-windup;
- output saturation.

It sits between the per-channel speed/reference registers and the PWM duty generators. One `sample_start` pulse per control period updates every channel's `N_con`.

## Interface
Parameters:
- `W`, 19: data and gain width, signed.
- `FRAC`, 15: fractional bits of `K_p`, `K_i` and `K_d`.
- `N_CH`, 4: channel count, 1..16.
- `INT_LIM`, 2**(W-1)-1: integrator magnitude clamp, applied as ±`INT_LIM`.
- `OUT_MAX`, 2**(W-1)-1: upper saturation of `N_con`.
- `OUT_MIN`, -(2**(W-1)): lower saturation of `N_con`.

Ports:
- `up_clk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `sample_start`, in, 1: one-cycle pulse that starts a control update of all channels.
- `N_ref`, in, `N_CH*W`: per-channel signed reference. Channel c occupies bits [c*W +: W].
- `N_fb`, in, `N_CH*W`: per-channel signed feedback.
- `K_p`, `K_i`, `K_d`, in, `N_CH*W` each: per-channel signed gains.
- `int_clr`, in, `N_CH`: per-channel synchronous integrator and derivative-history clear.
- `N_con`, out, `N_CH*W`: per-channel signed, saturated control output.
- `busy`, out, 1: an update is in progress.
- `done`, out, 1: one-cycle pulse when all channels have been written.

## Operation
- FSM states: IDLE → ERR → MP → MI → MD → ACC → (next channel ? ERR : DONE) → IDLE. Channel index `c` runs 0..N_CH−1.
- **IDLE:** `sample_start`=1 sets `c`=0 and moves to ERR. `sample_start` is ignored in every other state; no queueing.
- **ERR:**
  - e = N_ref[c] − N_fb[c], width W+1.
  - de = e − e_prev[c], width W+2.
  - `N_ref`, `N_fb` and gains are sampled here, so inputs need only be stable during channel c's ERR/MP/MI/MD cycles.
- **MP:** p = (K_p·e) >>> FRAC, arithmetic shift (floor).
- **MI:** i_inc = (K_i·e) >>> FRAC.
- **MD:** d = (K_d·de) >>> FRAC.
- The shared multiplier has width W × (W+2) → 2W+2, one product per cycle.
- **ACC, integrator update:**
  - Candidate i_new = clamp(I[c] + i_inc, ±INT_LIM).
  - Anti-windup: if the previous `N_con[c]` is at `OUT_MAX` and i_inc>0, or at `OUT_MIN` and i_inc<0, I[c] holds. Otherwise I[c] ← i_new.
- **ACC, output:**
  - u = p + I[c](updated) + d, computed at full width.
  - `N_con[c]` ← clamp(u, OUT_MIN, OUT_MAX).
  - e_prev[c] ← e.
- **DONE:** `done`=1 for one cycle, then return to IDLE.
- **`int_clr[c]`:**
  - When asserted, I[c] and e_prev[c] are forced to 0 on every clock edge, and take priority over any ACC write.
  - `N_con[c]` is unaffected.
- All intermediate sums use enough width to avoid overflow before clamping (2W+3 bits suffices).

## Timing
- Reset values: `N_con`=0 on all channels, `busy`=0, `done`=0, I=0, e_prev=0, state IDLE.
- Reset asserted mid-update aborts the update immediately. No partial `done` is produced. Channels already written in that update are also reset to 0.
- Update length: 5·N_CH cycles from the `sample_start` edge to the last ACC write.
- `done` is asserted at cycle 5·N_CH+1 after `sample_start`.
- `busy` is high from the cycle after `sample_start` through the DONE cycle.
- `N_con[c]` changes on the ACC edge of channel c, which is cycle 5c+5 after `sample_start`. It is otherwise stable.
- A `sample_start` in the same cycle as `done` is ignored. The earliest accepted restart is the cycle after DONE.

## Structure
- Package `pid_pkg`:
  - FSM state enum: IDLE, ERR, MP, MI, MD, ACC, DONE.
  - Saturate/clamp function, parametrised by width.
  - Q-format helper constant for `FRAC`.
- Sub-module `pid_mul`: registered signed W × (W+2) multiply with arithmetic shift by `FRAC`. It is the single shared datapath multiplier.
- Per-channel state lives in register arrays indexed by `c`: I, e_prev, `N_con`.

## Test plan
Unless stated otherwise, W=19, FRAC=15, N_CH=4, and gains are in Q.15 (1.0 = 32768).
1. **Reset:** assert `rst` during an update at cycle 7 → all `N_con`=0, `busy`=0, no `done`.
2. **P only, ch0:** K_p=32768, N_ref=1000, N_fb=0, K_i=K_d=0 → `N_con[0]`=1000 at cycle 5; `done` at cycle 21.
3. **Integrator, ch1:** K_i=16384, e=200, 3 updates → `N_con[1]`=100, 200, 300.
4. **Derivative, ch2:** K_d=32768, e goes 0 then 500 → `N_con[2]`=500, next update (e=500) → 0.
5. **Saturation and anti-windup, ch3:**
   - Setup: OUT_MAX=1000, K_i=32768, e=800.
   - Updates 1–2: `N_con[3]`=800, then 1000 (clamped); I[3] reaches 1600 on update 2.
   - Update 3: `N_con[3]` is already at OUT_MAX and i_inc>0, so I[3] holds at 1600.
   - Update 4: e=−400 → I[3]=1200, `N_con[3]`=1000 (still clamped).
6. **Misc:** `sample_start` while `busy` → ignored, and `done` count equals the accepted starts. `int_clr[1]`=1 → I[1]=0 on the next update.
